wb_arbiter: RTL

Writeback arbiter downstream of the load/store unit. Merges three result sources onto the single physical-register-file write port and the reorder-buffer completion bus: ALU results, load results (`vld_ld`/`indx_ld`/`phy_addr_ld`/`data_ld`/`reg_wrt_ld` from the load queue) and multiplier results. Load results are one-shot pulses that cannot be back-pressured, so they are held in a small FIFO. The block raises a stall toward issue before that FIFO can overflow.

---
 rtl/wb_arbiter_pkg.sv | 36 +++
 rtl/wb_arbiter_if.sv | 57 +++++
 rtl/wb_arbiter_ld_fifo.sv | 70 +++++++
 rtl/wb_arbiter.sv | 131 +++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: field widths, result record and source select.
package wb_pkg;

    localparam int IDX_W  = 6;
    localparam int PHY_W  = 6;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic [IDX_W-1:0]  indx;
        logic [PHY_W-1:0]  phy;
        logic [DATA_W-1:0] data;
        logic              wrt;
    } wb_res_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ALU  = 2'd1,
        LD   = 2'd2,
        MUL  = 2'd3
    } wb_src_e;

    function automatic wb_res_t mk_res(
        input logic [IDX_W-1:0]  indx,
        input logic [PHY_W-1:0]  phy,
        input logic [DATA_W-1:0] data,
        input logic              wrt
    );
        wb_res_t r;
        r.indx = indx;
        r.phy  = phy;
        r.data = data;
        r.wrt  = wrt;
        return r;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: three result sources in, register-file/ROB/wakeup/stall out.
interface wb_arbiter_if;
    import wb_pkg::*;

    logic              flsh;

    logic              alu_vld;
    logic [IDX_W-1:0]  alu_indx;
    logic [PHY_W-1:0]  alu_phy;
    logic [DATA_W-1:0] alu_data;
    logic              alu_wrt;

    logic              vld_ld;
    logic [IDX_W-1:0]  indx_ld;
    logic [PHY_W-1:0]  phy_addr_ld;
    logic [DATA_W-1:0] data_ld;
    logic              reg_wrt_ld;

    logic              mul_vld;
    logic              mul_rdy;
    logic [IDX_W-1:0]  mul_indx;
    logic [PHY_W-1:0]  mul_phy;
    logic [DATA_W-1:0] mul_data;

    logic              rf_wrt_en;
    logic [PHY_W-1:0]  rf_wrt_addr;
    logic [DATA_W-1:0] rf_wrt_data;
    logic              cmmt_vld;
    logic [IDX_W-1:0]  cmmt_indx;
    logic              wkup_vld;
    logic [PHY_W-1:0]  wkup_tag;
    logic              stll_wb;
    logic              ovf_err;

    modport master (
        output flsh,
        output alu_vld, alu_indx, alu_phy, alu_data, alu_wrt,
        output vld_ld, indx_ld, phy_addr_ld, data_ld, reg_wrt_ld,
        output mul_vld, mul_indx, mul_phy, mul_data,
        input  mul_rdy,
        input  rf_wrt_en, rf_wrt_addr, rf_wrt_data,
        input  cmmt_vld, cmmt_indx, wkup_vld, wkup_tag,
        input  stll_wb, ovf_err
    );

    modport slave (
        input  flsh,
        input  alu_vld, alu_indx, alu_phy, alu_data, alu_wrt,
        input  vld_ld, indx_ld, phy_addr_ld, data_ld, reg_wrt_ld,
        input  mul_vld, mul_indx, mul_phy, mul_data,
        output mul_rdy,
        output rf_wrt_en, rf_wrt_addr, rf_wrt_data,
        output cmmt_vld, cmmt_indx, wkup_vld, wkup_tag,
        output stll_wb, ovf_err
    );

endinterface

// File: rtl/wb_arbiter_ld_fifo.sv
// wb_ld_fifo: circular buffer of load results; a push while full is ignored, flush empties it.
module wb_ld_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push_i,
    input  wb_res_t        push_data_i,
    input  logic           pop_i,
    input  logic           flush_i,
    output wb_res_t        head_o,
    output logic [PTR_W:0] count_nxt_o,
    output logic           full_o,
    output logic           empty_o
);

    wb_res_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    assign count_nxt_o = count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read while the count covers it.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU > buffered load > multiplier onto one RF port and the ROB bus.
// Optional WB_LD_BYPASS_EN lets a load skip an empty FIFO when no ALU result competes.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned STLL_THR = DEPTH - 1
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    wb_res_t        alu_res, ld_res, mul_res, head_res, win_res;
    wb_src_e        src_sel;
    logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [PTR_W:0] count_nxt;
    logic           ld_byp, mul_rdy;

    logic              vld_q, vld_d;
    logic              wrt_q, wrt_d;
    logic [PHY_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  indx_q, indx_d;
    logic              stll_q, stll_d;
    logic              ovf_q, ovf_d;

    assign alu_res = mk_res(bus.alu_indx, bus.alu_phy, bus.alu_data, bus.alu_wrt);
    assign ld_res  = mk_res(bus.indx_ld, bus.phy_addr_ld, bus.data_ld, bus.reg_wrt_ld);
    assign mul_res = mk_res(bus.mul_indx, bus.mul_phy, bus.mul_data, 1'b1);

`ifdef WB_LD_BYPASS_EN
    assign ld_byp  = bus.vld_ld && fifo_empty && !bus.alu_vld && !bus.flsh;
    assign mul_rdy = !bus.alu_vld && fifo_empty && !bus.flsh && !bus.vld_ld;
`else
    assign ld_byp  = 1'b0;
    assign mul_rdy = !bus.alu_vld && fifo_empty && !bus.flsh;
`endif

    assign bus.mul_rdy = mul_rdy;

    wb_ld_fifo #(
        .DEPTH (DEPTH)
    ) u_ld_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (ld_res),
        .pop_i       (fifo_pop),
        .flush_i     (bus.flsh),
        .head_o      (head_res),
        .count_nxt_o (count_nxt),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign fifo_push = bus.vld_ld && !bus.flsh && !ld_byp;

    always_comb begin
        src_sel  = NONE;
        win_res  = alu_res;
        fifo_pop = 1'b0;
        if (!bus.flsh) begin
            if (bus.alu_vld) begin
                src_sel = ALU;
                win_res = alu_res;
            end else if (!fifo_empty) begin
                src_sel  = LD;
                win_res  = head_res;
                fifo_pop = 1'b1;
            end else if (ld_byp) begin
                src_sel = LD;
                win_res = ld_res;
            end else if (bus.mul_vld && mul_rdy) begin
                src_sel = MUL;
                win_res = mul_res;
            end
        end
    end

    // Address, data and index hold across idle cycles; only the valids drop.
    always_comb begin
        vld_d  = 1'b0;
        wrt_d  = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        indx_d = indx_q;
        if (src_sel != NONE) begin
            vld_d  = 1'b1;
            wrt_d  = win_res.wrt;
            addr_d = win_res.phy;
            data_d = win_res.data;
            indx_d = win_res.indx;
        end
        stll_d = (32'(count_nxt) >= STLL_THR);
        ovf_d  = ovf_q || (fifo_push && fifo_full);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            wrt_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            indx_q <= '0;
            stll_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            wrt_q  <= wrt_d;
            addr_q <= addr_d;
            data_q <= data_d;
            indx_q <= indx_d;
            stll_q <= stll_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.rf_wrt_en   = vld_q && wrt_q;
    assign bus.rf_wrt_addr = addr_q;
    assign bus.rf_wrt_data = data_q;
    assign bus.cmmt_vld    = vld_q;
    assign bus.cmmt_indx   = indx_q;
    assign bus.wkup_vld    = vld_q && wrt_q;
    assign bus.wkup_tag    = addr_q;
    assign bus.stll_wb     = stll_q;
    assign bus.ovf_err     = ovf_q;

endmodule
